// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
// wb_req_t is sized by the defaults; parameter overrides must not exceed them.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] wd;
        logic                  kill;
    } wb_req_t;

    // A dequeued entry reaches the register file only if nothing younger
    // already overwrote its target and it does not target the zero register.
    function automatic logic is_live_write(input wb_req_t req);
        return !req.kill && (req.rd != '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular queue of pending load writebacks, with an extra pointer bit for
// full/empty and a per-entry destination match so younger writes can kill entries.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_push,
    input  wb_req_t                          i_push_req,
    input  logic                             i_pop,
    input  logic [REG_ADDR_W-1:0]            i_kill_rd,
    input  logic [DEPTH-1:0]                 i_kill_set,
    output wb_req_t                          o_head,
    output logic                             o_empty,
    output logic                             o_full,
    output logic [DEPTH-1:0]                 o_kill_match,
    output logic [DEPTH-1:0]                 o_entry_live,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] o_entry_rd
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]           r_wr_ptr;
    logic [PW:0]           r_rd_ptr;
    logic [DEPTH-1:0]      r_kill;
    logic [REG_ADDR_W-1:0] r_rd_mem [DEPTH];
    logic [REG_DATA_W-1:0] r_wd_mem [DEPTH];

    logic [PW:0]      w_count;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_rd_idx;
    logic [DEPTH-1:0] w_valid;

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_wr_idx = r_wr_ptr[PW-1:0];
    assign w_rd_idx = r_rd_ptr[PW-1:0];
    assign o_empty  = (w_count == '0);
    assign o_full   = (w_count == (PW+1)'(DEPTH));

    // An entry is occupied when its distance from the read pointer is below the fill count.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
        w_valid      = '0;
        o_kill_match = '0;
        o_entry_live = '0;
        o_entry_rd   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i]      = {1'b0, PW'(i) - w_rd_idx} < w_count;
            o_kill_match[i] = w_valid[i] && (r_rd_mem[i] == i_kill_rd);
            o_entry_live[i] = w_valid[i] && !r_kill[i];
            o_entry_rd[i]   = r_rd_mem[i];
        end
    end

    assign o_head = '{rd: r_rd_mem[w_rd_idx], wd: r_wd_mem[w_rd_idx], kill: r_kill[w_rd_idx]};

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_kill   <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (w_wr_idx == PW'(i))) r_kill[i] <= i_push_req.kill;
                else if (i_kill_set[i])             r_kill[i] <= 1'b1;
            end
        end
    end

    // NOTE: payload storage is deliberately left unreset; occupancy comes only from the pointers.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_rd_mem[w_wr_idx] <= i_push_req.rd;
            r_wd_mem[w_wr_idx] <= i_push_req.wd;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and queued load results.
// Optional macro WB_BYPASS_EN: a load arriving to an empty queue with the ALU idle is written directly.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH    = REG_DATA_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_wd,
    output logic                          alu_stall,
    input  logic                          mem_valid,
    input  logic [ADDRESS_WIDTH-1:0]      mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_wd,
    output logic                          mem_ready,
    output logic                          WE3,
    output logic [ADDRESS_WIDTH-1:0]      AD3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic [(1<<ADDRESS_WIDTH)-1:0] pend_mask
);

    localparam int SW = $clog2(STARVE_LIMIT + 2);

    logic [SW-1:0] r_starve;

    wb_req_t                              w_head;
    wb_req_t                              w_push_req;
    logic                                 w_empty;
    logic                                 w_full;
    logic                                 w_force;
    logic                                 w_pop;
    logic                                 w_alu_acc;
    logic                                 w_kill_en;
    logic                                 w_bypass;
    logic                                 w_push;
    logic [FIFO_DEPTH-1:0]                w_kill_match;
    logic [FIFO_DEPTH-1:0]                w_kill_set;
    logic [FIFO_DEPTH-1:0]                w_live;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_entry_rd;

    // The queue head wins outright once it has waited STARVE_LIMIT cycles behind the ALU.
    assign w_force   = !w_empty && (r_starve == SW'(STARVE_LIMIT));
    assign w_pop     = !rst && !w_empty && (w_force || !alu_valid);
    assign w_alu_acc = !rst && alu_valid && !w_force;
    assign alu_stall = !rst && alu_valid && w_force;
    assign w_kill_en = w_alu_acc && (alu_rd != '0);
    assign w_kill_set = w_kill_en ? w_kill_match : '0;

    assign mem_ready = !rst && !w_full;

`ifdef WB_BYPASS_EN
    assign w_bypass = !rst && mem_valid && w_empty && !alu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = mem_valid && mem_ready && !w_bypass;

    // A load accepted alongside a same-register ALU write is older, so it enters already dead.
    assign w_push_req = '{rd:   REG_ADDR_W'(mem_rd),
                          wd:   REG_DATA_W'(mem_wd),
                          kill: w_kill_en && (mem_rd == alu_rd)};

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_req  (w_push_req),
        .i_pop       (w_pop),
        .i_kill_rd   (REG_ADDR_W'(alu_rd)),
        .i_kill_set  (w_kill_set),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_kill_match(w_kill_match),
        .o_entry_live(w_live),
        .o_entry_rd  (w_entry_rd)
    );

    always_comb begin
        WE3 = 1'b0;
        AD3 = '0;
        WD3 = '0;
        if (w_pop) begin
            WE3 = is_live_write(w_head);
            AD3 = ADDRESS_WIDTH'(w_head.rd);
            WD3 = DATA_WIDTH'(w_head.wd);
        end else if (w_alu_acc) begin
            WE3 = (alu_rd != '0);
            AD3 = alu_rd;
            WD3 = alu_wd;
        end else if (w_bypass) begin
            WE3 = (mem_rd != '0);
            AD3 = mem_rd;
            WD3 = mem_wd;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_live[i]) pend_mask[ADDRESS_WIDTH'(w_entry_rd[i])] = 1'b1;
        end
        pend_mask[0] = 1'b0;
        if (rst) pend_mask = '0;
    end

    always_ff @(posedge clk) begin
        if (rst || w_empty || w_pop) r_starve <= '0;
        else                         r_starve <= r_starve + SW'(1);
    end

endmodule
